// File: rtl/random_pulse_scheduler.sv
// rtl/random_pulse_scheduler.sv - burst of pulses at pseudo-random intervals drawn from a 16-bit LFSR
// All outputs are registered from the current state, so each lags its state by one cycle.
module random_pulse_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      cfg_seed,
  input  logic [15:0]      cfg_mask,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [CNT_W-1:0] cfg_gap,
  output logic             busy,
  output logic             done,
  output logic             pulse,
  output logic [CNT_W-1:0] pulse_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_FIRE,
    S_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      mask_q, mask_d;
  logic [15:0]      timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] emitted_q, emitted_d;
  logic [CNT_W-1:0] pulse_idx_q, pulse_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W:0]   emitted_inc;
  logic             lfsr_fb;

  // One extra bit so an all-ones count completes without wrapping.
  assign emitted_inc = {1'b0, emitted_q} + (CNT_W+1)'(1);
  assign lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    mask_d      = mask_q;
    timer_d     = timer_q;
    count_d     = count_q;
    gap_d       = gap_q;
    emitted_d   = emitted_q;
    pulse_idx_d = pulse_idx_q;
    busy_d      = (state_q != S_IDLE);
    done_d      = 1'b0;
    pulse_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lfsr_d    = (cfg_seed == 16'h0000) ? 16'h0001 : cfg_seed;
          mask_d    = cfg_mask;
          count_d   = cfg_count;
          gap_d     = cfg_gap;
          emitted_d = '0;
          state_d   = (cfg_count == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        timer_d = lfsr_q & mask_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timer_q == 16'h0000) state_d = S_FIRE;
        else                     timer_d = timer_q - 16'd1;
      end
      S_FIRE: begin
        pulse_d     = 1'b1;
        pulse_idx_d = emitted_q;
        emitted_d   = emitted_inc[CNT_W-1:0];
        lfsr_d      = {lfsr_q[14:0], lfsr_fb};
        if (emitted_inc == {1'b0, count_q}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_GAP;
          timer_d = 16'(gap_q);
        end
      end
      S_GAP: begin
        if (timer_q == 16'h0000) state_d = S_LOAD;
        else                     timer_d = timer_q - 16'd1;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a FIRE or DONE in flight.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      lfsr_d      = lfsr_q;
      emitted_d   = emitted_q;
      pulse_idx_d = pulse_idx_q;
      pulse_d     = 1'b0;
      done_d      = 1'b0;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= 16'h0001;
      mask_q      <= 16'h0000;
      timer_q     <= 16'h0000;
      count_q     <= '0;
      gap_q       <= '0;
      emitted_q   <= '0;
      pulse_idx_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      mask_q      <= mask_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      emitted_q   <= emitted_d;
      pulse_idx_q <= pulse_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pulse_q     <= pulse_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse     = pulse_q;
  assign pulse_idx = pulse_idx_q;

endmodule

// File: tb/tb_random_pulse_scheduler.sv
// tb/tb_random_pulse_scheduler.sv - randomized self-checking bench for random_pulse_scheduler
module tb_random_pulse_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg_seed;
  logic [15:0] cfg_mask;
  logic [7:0]  cfg_count;
  logic [7:0]  cfg_gap;
  logic        busy;
  logic        done;
  logic        pulse;
  logic [7:0]  pulse_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  random_pulse_scheduler #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_seed  (cfg_seed),
    .cfg_mask  (cfg_mask),
    .cfg_count (cfg_count),
    .cfg_gap   (cfg_gap),
    .busy      (busy),
    .done      (done),
    .pulse     (pulse),
    .pulse_idx (pulse_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected schedule comes from the timing rules: first pulse at interval0+3,
  // then gap+interval+4 apart, done one cycle after the last pulse, busy low one after that.
  task automatic run_burst(input logic [15:0] seed, input logic [15:0] mask,
                           input logic [7:0] cnt, input logic [7:0] gap,
                           input int abort_cyc, input int restart_cyc);
    int          exp_cyc[$];
    int          obs_cyc[$];
    int          obs_idx[$];
    logic [15:0] l;
    int          t;
    int          exp_done, exp_busy_lo, obs_done, obs_busy_lo, n_done, horizon, n_cmp;

    l = (seed == 16'h0000) ? 16'h0001 : seed;
    t = 0;
    for (int i = 0; i < int'(cnt); i++) begin
      if (i == 0) t = int'(l & mask) + 3;
      else        t = t + int'(gap) + int'(l & mask) + 4;
      exp_cyc.push_back(t);
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    exp_done    = (cnt == 8'd0) ? 1 : t + 1;
    exp_busy_lo = exp_done + 1;
    if (abort_cyc > 0) begin
      while (exp_cyc.size() > 0 && exp_cyc[$] >= abort_cyc) void'(exp_cyc.pop_back());
      if (exp_done >= abort_cyc) exp_done = -1;
      if (exp_busy_lo > abort_cyc) exp_busy_lo = abort_cyc;
    end
    horizon = exp_busy_lo + 10;

    @(negedge clk);
    cfg_seed  = seed;
    cfg_mask  = mask;
    cfg_count = cnt;
    cfg_gap   = gap;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    cfg_seed  = 16'($urandom);
    cfg_mask  = 16'($urandom);
    cfg_count = 8'($urandom);
    cfg_gap   = 8'($urandom);

    obs_done    = -1;
    obs_busy_lo = -1;
    n_done      = 0;
    for (int c = 1; c <= horizon; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (pulse) begin
        obs_cyc.push_back(c);
        obs_idx.push_back(int'(pulse_idx));
      end
      if (done) begin
        n_done++;
        if (obs_done < 0) obs_done = c;
      end
      if (!busy && obs_busy_lo < 0 && c >= 2) obs_busy_lo = c;
      abort = (c + 1 == abort_cyc);
      if (c + 1 == restart_cyc) begin
        start     = 1'b1;
        cfg_seed  = 16'hBEEF;
        cfg_mask  = 16'h00FF;
        cfg_count = 8'd7;
        cfg_gap   = 8'd9;
      end else begin
        start = 1'b0;
      end
    end
    abort = 1'b0;
    start = 1'b0;

    check("n_pulse", obs_cyc.size(), exp_cyc.size());
    n_cmp = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n_cmp; i++) begin
      check($sformatf("pulse%0d_cyc", i), obs_cyc[i], exp_cyc[i]);
      check($sformatf("pulse%0d_idx", i), obs_idx[i], i);
    end
    check("done_cnt", n_done, (exp_done < 0) ? 0 : 1);
    if (exp_done >= 0) check("done_cyc", obs_done, exp_done);
    check("busy_lo", obs_busy_lo, exp_busy_lo);
  endtask

  task automatic reset_mid_burst();
    int n_pulse, n_done, n_busy;
    @(negedge clk);
    cfg_seed  = 16'h0001;
    cfg_mask  = 16'h000F;
    cfg_count = 8'd3;
    cfg_gap   = 8'd5;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("gap_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_pulse", pulse, 0);
    check("arst_idx", pulse_idx, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    n_pulse = 0;
    n_done  = 0;
    n_busy  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pulse) n_pulse++;
      if (done)  n_done++;
      if (busy)  n_busy++;
    end
    check("arst_post_pulse", n_pulse, 0);
    check("arst_post_done", n_done, 0);
    check("arst_post_busy", n_busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    cfg_seed  = 16'h0000;
    cfg_mask  = 16'h0000;
    cfg_count = 8'd0;
    cfg_gap   = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pulse", pulse, 0);
    check("rst_idx", pulse_idx, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);

    run_burst(16'h0001, 16'h000F, 8'd3, 8'd0, 0, 0);
    run_burst(16'h1234, 16'h000F, 8'd0, 8'd0, 0, 0);
    run_burst(16'h0000, 16'h000F, 8'd1, 8'd2, 0, 0);
    run_burst(16'h0001, 16'h000F, 8'd3, 8'd0, 8, 0);
    run_burst(16'h0001, 16'h000F, 8'd3, 8'd0, 0, 0);
    run_burst(16'h0001, 16'h000F, 8'd3, 8'd0, 0, 6);
    reset_mid_burst();
    run_burst(16'h0001, 16'h000F, 8'd3, 8'd0, 0, 0);
    run_burst(16'($urandom), 16'h0003, 8'hFF, 8'd0, 0, 0);

    for (int k = 0; k < 12; k++) begin
      logic [15:0] s, m;
      logic [7:0]  n, g;
      int          a;
      s = 16'($urandom);
      m = 16'($urandom) & 16'h001F;
      n = 8'($urandom_range(0, 6));
      g = 8'($urandom_range(0, 5));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 40)) : 0;
      run_burst(s, m, n, g, a, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
